// File: rtl/dcache_pkg.sv
// Shared types and constants for the direct-mapped data cache.
// Optional statistics counters are enabled with DCACHE_STATS_EN.
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        FETCH,
        FILL
    } state_t;

    localparam int OFFSET_BITS = 2;
    localparam int ADDR_W      = 8;
    localparam int BLOCK_W     = 32;

    function automatic int tag_width(input int index_bits);
        return ADDR_W - OFFSET_BITS - index_bits;
    endfunction

endpackage

// File: rtl/dcache_line_array.sv
// Line storage: valid/dirty/tag/data with combinational read and
// one synchronous write port (full block fill or single byte merge).
module dcache_line_array
    import dcache_pkg::*;
#(
    parameter int INDEX_BITS = 3,
    parameter int TAG_W      = 3
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [INDEX_BITS-1:0] idx,
    output logic                  valid,
    output logic                  dirty,
    output logic [TAG_W-1:0]      tag,
    output logic [BLOCK_W-1:0]    block,
    input  logic                  we,
    input  logic                  fill,
    input  logic [TAG_W-1:0]      wtag,
    input  logic [BLOCK_W-1:0]    wblock,
    input  logic [1:0]            woff,
    input  logic [7:0]            wbyte
);

    localparam int LINES = 1 << INDEX_BITS;

    logic [LINES-1:0]   valid_q;
    logic [LINES-1:0]   dirty_q;
    logic [TAG_W-1:0]   tag_q  [LINES];
    logic [BLOCK_W-1:0] data_q [LINES];

    assign valid = valid_q[idx];
    assign dirty = dirty_q[idx];
    assign tag   = tag_q[idx];
    assign block = data_q[idx];

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            valid_q <= '0;
            dirty_q <= '0;
            for (int i = 0; i < LINES; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else if (we) begin
            if (fill) begin
                data_q[idx]  <= wblock;
                tag_q[idx]   <= wtag;
                valid_q[idx] <= 1'b1;
                dirty_q[idx] <= 1'b0;
            end else begin
                data_q[idx][{woff, 3'b000} +: 8] <= wbyte;
                dirty_q[idx] <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/dcache_direct.sv
// Direct-mapped write-back, write-allocate byte cache with miss FSM.
// Define DCACHE_STATS_EN to add saturating HIT_COUNT/MISS_COUNT ports.
module dcache_direct
    import dcache_pkg::*;
#(
    parameter int INDEX_BITS  = 3,
    parameter int BLOCK_BYTES = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        READ,
    input  logic        WRITE,
    input  logic [7:0]  ADDRESS,
    input  logic [7:0]  WRITEDATA,
    output logic [7:0]  READDATA,
    output logic        BUSYWAIT,
    output logic        MEM_READ,
    output logic        MEM_WRITE,
    output logic [5:0]  MEM_ADDRESS,
    output logic [31:0] MEM_WRITEDATA,
    input  logic [31:0] MEM_READDATA,
    input  logic        MEM_BUSYWAIT
`ifdef DCACHE_STATS_EN
    ,
    output logic [15:0] HIT_COUNT,
    output logic [15:0] MISS_COUNT
`endif
);

    localparam int TAG_W = tag_width(INDEX_BITS);
    localparam int BLK_W = BLOCK_BYTES * 8;

    state_t state_q, state_d;

    logic [TAG_W-1:0]      a_tag;
    logic [INDEX_BITS-1:0] a_idx;
    logic [1:0]            a_off;

    logic [TAG_W-1:0]      m_tag;
    logic [INDEX_BITS-1:0] m_idx;
    logic [BLK_W-1:0]      fill_buf;
    logic [7:0]            rdata_q;

    logic [INDEX_BITS-1:0] l_idx;
    logic                  l_valid;
    logic                  l_dirty;
    logic [TAG_W-1:0]      l_tag;
    logic [BLOCK_W-1:0]    l_block;

    logic       req, hit, busy, rd_hit, we, fill;
    logic [7:0] sel_byte;

    assign a_tag = ADDRESS[ADDR_W-1 -: TAG_W];
    assign a_idx = ADDRESS[OFFSET_BITS +: INDEX_BITS];
    assign a_off = ADDRESS[1:0];

    assign req      = READ | WRITE;
    assign l_idx    = (state_q == IDLE) ? a_idx : m_idx;
    assign hit      = l_valid && (l_tag == a_tag);
    assign sel_byte = l_block[{a_off, 3'b000} +: 8];

    dcache_line_array #(
        .INDEX_BITS(INDEX_BITS),
        .TAG_W     (TAG_W)
    ) u_lines (
        .CLK   (CLK),
        .RESET (RESET),
        .idx   (l_idx),
        .valid (l_valid),
        .dirty (l_dirty),
        .tag   (l_tag),
        .block (l_block),
        .we    (we),
        .fill  (fill),
        .wtag  (m_tag),
        .wblock(fill_buf),
        .woff  (a_off),
        .wbyte (WRITEDATA)
    );

    always_comb begin
        state_d       = state_q;
        busy          = 1'b0;
        rd_hit        = 1'b0;
        we            = 1'b0;
        fill          = 1'b0;
        MEM_READ      = 1'b0;
        MEM_WRITE     = 1'b0;
        MEM_ADDRESS   = '0;
        MEM_WRITEDATA = '0;
        unique case (state_q)
            IDLE: begin
                if (req && hit) begin
                    we     = WRITE;
                    rd_hit = ~WRITE;
                end else if (req) begin
                    busy    = 1'b1;
                    state_d = (l_valid && l_dirty) ? WRITEBACK : FETCH;
                end
            end
            WRITEBACK: begin
                busy          = 1'b1;
                MEM_WRITE     = 1'b1;
                MEM_ADDRESS   = {l_tag, m_idx};
                MEM_WRITEDATA = l_block;
                if (!MEM_BUSYWAIT) state_d = FETCH;
            end
            FETCH: begin
                busy        = 1'b1;
                MEM_READ    = 1'b1;
                MEM_ADDRESS = {m_tag, m_idx};
                if (!MEM_BUSYWAIT) state_d = FILL;
            end
            FILL: begin
                busy    = 1'b1;
                we      = 1'b1;
                fill    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset masks the stall even while a request is still presented.
    assign BUSYWAIT = busy & ~RESET;
    assign READDATA = rd_hit ? sel_byte : rdata_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= IDLE;
            m_tag    <= '0;
            m_idx    <= '0;
            fill_buf <= '0;
            rdata_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && state_d != IDLE) begin
                m_tag <= a_tag;
                m_idx <= a_idx;
            end
            if (state_q == FETCH && !MEM_BUSYWAIT) fill_buf <= MEM_READDATA;
            if (rd_hit) rdata_q <= sel_byte;
        end
    end

`ifdef DCACHE_STATS_EN
    // The hit that follows a fill is the retried miss, not a new hit.
    logic retry_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            retry_q    <= 1'b0;
            HIT_COUNT  <= '0;
            MISS_COUNT <= '0;
        end else begin
            if (state_q == FILL) retry_q <= 1'b1;
            else if (state_q == IDLE) retry_q <= 1'b0;
            if (state_q == IDLE && req && hit && !retry_q &&
                HIT_COUNT != 16'hFFFF)
                HIT_COUNT <= HIT_COUNT + 16'd1;
            if (state_q == IDLE && state_d != IDLE &&
                MISS_COUNT != 16'hFFFF)
                MISS_COUNT <= MISS_COUNT + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dcache_direct.sv
// Self-checking bench for dcache_direct with a latency-N word memory.
// Define DCACHE_STATS_EN to also check HIT_COUNT/MISS_COUNT.
module tb_dcache_direct;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        READ = 1'b0;
    logic        WRITE = 1'b0;
    logic [7:0]  ADDRESS = '0;
    logic [7:0]  WRITEDATA = '0;
    logic [7:0]  READDATA;
    logic        BUSYWAIT;
    logic        MEM_READ;
    logic        MEM_WRITE;
    logic [5:0]  MEM_ADDRESS;
    logic [31:0] MEM_WRITEDATA;
    logic [31:0] MEM_READDATA;
    logic        MEM_BUSYWAIT;
`ifdef DCACHE_STATS_EN
    logic [15:0] HIT_COUNT;
    logic [15:0] MISS_COUNT;
`endif

    dcache_direct dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .READ         (READ),
        .WRITE        (WRITE),
        .ADDRESS      (ADDRESS),
        .WRITEDATA    (WRITEDATA),
        .READDATA     (READDATA),
        .BUSYWAIT     (BUSYWAIT),
        .MEM_READ     (MEM_READ),
        .MEM_WRITE    (MEM_WRITE),
        .MEM_ADDRESS  (MEM_ADDRESS),
        .MEM_WRITEDATA(MEM_WRITEDATA),
        .MEM_READDATA (MEM_READDATA),
        .MEM_BUSYWAIT (MEM_BUSYWAIT)
`ifdef DCACHE_STATS_EN
        ,
        .HIT_COUNT    (HIT_COUNT),
        .MISS_COUNT   (MISS_COUNT)
`endif
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;
    int lat = 5;
    logic [7:0] sb [$];
    logic [7:0] ref_b [256];

    function automatic logic [31:0] init_word(input int i);
        logic [7:0] b;
        b = 8'(i);
        if (i == 1) return 32'h44332211;
        if (i == 9) return 32'h88776655;
        return {b ^ 8'hC3, b + 8'd7, ~b, b};
    endfunction

    // Backing memory: strobe held N cycles, completes in the Nth.
    logic [31:0] mem [64];
    bit   mem_inited;
    int   mcnt = 0;
    logic strobe;

    assign strobe       = MEM_READ | MEM_WRITE;
    assign MEM_BUSYWAIT = strobe && (mcnt != lat - 1);
    assign MEM_READDATA = mem[MEM_ADDRESS];

    always @(posedge CLK) begin
        if (!mem_inited) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
            mem_inited <= 1'b1;
        end else if (strobe) begin
            if (mcnt == lat - 1) begin
                if (MEM_WRITE) mem[MEM_ADDRESS] <= MEM_WRITEDATA;
                mcnt <= 0;
            end else begin
                mcnt <= mcnt + 1;
            end
        end else begin
            mcnt <= 0;
        end
    end

    int          cyc = 0;
    int          rd_total = 0;
    int          wr_total = 0;
    int          overlap = 0;
    int          rd_start = 0;
    int          wr_start = 0;
    logic        prev_rd = 1'b0;
    logic        prev_wr = 1'b0;
    logic [5:0]  rd_addr_l = '0;
    logic [5:0]  wr_addr_l = '0;
    logic [31:0] wr_data_l = '0;

    always begin
        @(negedge CLK);
        #2;
        cyc++;
        if (MEM_READ && MEM_WRITE) overlap++;
        if (MEM_READ) begin
            rd_total++;
            rd_addr_l = MEM_ADDRESS;
            if (!prev_rd) rd_start = cyc;
        end
        if (MEM_WRITE) begin
            wr_total++;
            wr_addr_l = MEM_ADDRESS;
            wr_data_l = MEM_WRITEDATA;
            if (!prev_wr) wr_start = cyc;
        end
        prev_rd = MEM_READ;
        prev_wr = MEM_WRITE;
    end

    task automatic access(input bit rd, input bit wr,
                          input logic [7:0] a, input logic [7:0] d,
                          output int busy);
        logic [7:0] exp;
        @(negedge CLK);
        READ = rd;
        WRITE = wr;
        ADDRESS = a;
        WRITEDATA = d;
        if (wr) ref_b[a] = d;
        else if (rd) sb.push_back(ref_b[a]);
        busy = 0;
        #1;
        while (BUSYWAIT === 1'b1 && busy < 200) begin
            busy++;
            @(negedge CLK);
            #1;
        end
        checks++;
        if (BUSYWAIT !== 1'b0) begin
            failures++;
            $display("FAIL stall_timeout addr=%h busy=%b", a, BUSYWAIT);
        end
        if (rd && !wr) begin
            exp = sb.pop_front();
            checks++;
            if (READDATA !== exp) begin
                failures++;
                $display("FAIL readdata addr=%h got=%h exp=%h",
                         a, READDATA, exp);
            end
        end
    endtask

    task automatic idle();
        @(negedge CLK);
        READ = 1'b0;
        WRITE = 1'b0;
    endtask

    task automatic resync_ref();
        for (int a = 0; a < 256; a++) begin
            logic [31:0] w;
            w = mem[a >> 2];
            ref_b[a] = w[(a % 4) * 8 +: 8];
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        #1;
        checks++;
        if ({BUSYWAIT, MEM_READ, MEM_WRITE} !== 3'b000) begin
            failures++;
            $display("FAIL reset_strobes got=%b exp=000",
                     {BUSYWAIT, MEM_READ, MEM_WRITE});
        end
        checks++;
        if (READDATA !== 8'h00) begin
            failures++;
            $display("FAIL reset_readdata got=%h exp=00", READDATA);
        end
        checks++;
        if (MEM_ADDRESS !== 6'h00 || MEM_WRITEDATA !== 32'h0) begin
            failures++;
            $display("FAIL reset_memaddr got=%h/%h exp=0/0",
                     MEM_ADDRESS, MEM_WRITEDATA);
        end
        RESET = 1'b0;
    endtask

    task automatic test_cold_miss();
        int b, r0, w0;
        r0 = rd_total;
        w0 = wr_total;
        access(1, 0, 8'h05, 8'h00, b);
        checks++;
        if (b != 7) begin
            failures++;
            $display("FAIL cold_busy got=%0d exp=7", b);
        end
        checks++;
        if (rd_total - r0 != 5) begin
            failures++;
            $display("FAIL cold_memread got=%0d exp=5", rd_total - r0);
        end
        checks++;
        if (wr_total != w0) begin
            failures++;
            $display("FAIL cold_memwrite got=%0d exp=0", wr_total - w0);
        end
        checks++;
        if (rd_addr_l !== 6'h01) begin
            failures++;
            $display("FAIL cold_addr got=%h exp=01", rd_addr_l);
        end
    endtask

    task automatic test_hits();
        int b, r0;
        r0 = rd_total;
        access(1, 0, 8'h07, 8'h00, b);
        checks++;
        if (b != 0) begin
            failures++;
            $display("FAIL hit_read_busy got=%0d exp=0", b);
        end
        access(0, 1, 8'h06, 8'hAB, b);
        checks++;
        if (b != 0) begin
            failures++;
            $display("FAIL hit_write_busy got=%0d exp=0", b);
        end
        access(1, 0, 8'h06, 8'h00, b);
        idle();
        #1;
        checks++;
        if (READDATA !== 8'hAB || BUSYWAIT !== 1'b0) begin
            failures++;
            $display("FAIL idle_hold got=%h/%b exp=ab/0",
                     READDATA, BUSYWAIT);
        end
        checks++;
        if (rd_total != r0) begin
            failures++;
            $display("FAIL hit_memread got=%0d exp=0", rd_total - r0);
        end
    endtask

    task automatic test_dirty_evict();
        int b, r0, w0;
        r0 = rd_total;
        w0 = wr_total;
        access(1, 0, 8'h25, 8'h00, b);
        checks++;
        if (b != 12) begin
            failures++;
            $display("FAIL dirty_busy got=%0d exp=12", b);
        end
        checks++;
        if (wr_total - w0 != 5 || rd_total - r0 != 5) begin
            failures++;
            $display("FAIL dirty_strobes got=%0d/%0d exp=5/5",
                     wr_total - w0, rd_total - r0);
        end
        checks++;
        if (wr_addr_l !== 6'h01 || wr_data_l !== 32'h44AB2211) begin
            failures++;
            $display("FAIL dirty_victim got=%h/%h exp=01/44ab2211",
                     wr_addr_l, wr_data_l);
        end
        checks++;
        if (rd_addr_l !== 6'h09 || !(wr_start < rd_start)) begin
            failures++;
            $display("FAIL dirty_fetch got=%h ws=%0d rs=%0d exp=09",
                     rd_addr_l, wr_start, rd_start);
        end
        checks++;
        if (mem[1] !== 32'h44AB2211) begin
            failures++;
            $display("FAIL dirty_mem got=%h exp=44ab2211", mem[1]);
        end
    endtask

    task automatic test_clean_evict();
        int b, w0;
        w0 = wr_total;
        access(1, 0, 8'h05, 8'h00, b);
        checks++;
        if (b != 7 || wr_total != w0) begin
            failures++;
            $display("FAIL clean_evict got=%0d/%0d exp=7/0",
                     b, wr_total - w0);
        end
`ifdef DCACHE_STATS_EN
        checks++;
        if (HIT_COUNT !== 16'd3 || MISS_COUNT !== 16'd3) begin
            failures++;
            $display("FAIL stats got=%0d/%0d exp=3/3",
                     HIT_COUNT, MISS_COUNT);
        end
`endif
        access(1, 0, 8'h06, 8'h00, b);
    endtask

    task automatic test_reset_mid_fetch();
        int b, n;
        @(negedge CLK);
        READ = 1'b1;
        WRITE = 1'b0;
        ADDRESS = 8'h25;
        n = 0;
        while (MEM_READ !== 1'b1 && n < 50) begin
            @(negedge CLK);
            n++;
        end
        checks++;
        if (MEM_READ !== 1'b1) begin
            failures++;
            $display("FAIL rst_fetch_start got=%b exp=1", MEM_READ);
        end
        @(negedge CLK);
        RESET = 1'b1;
        #1;
        checks++;
        if ({MEM_READ, BUSYWAIT, READDATA} !== 10'h0) begin
            failures++;
            $display("FAIL rst_mid got=%b%b/%h exp=00/00",
                     MEM_READ, BUSYWAIT, READDATA);
        end
`ifdef DCACHE_STATS_EN
        checks++;
        if (HIT_COUNT !== 16'd0 || MISS_COUNT !== 16'd0) begin
            failures++;
            $display("FAIL rst_stats got=%0d/%0d exp=0/0",
                     HIT_COUNT, MISS_COUNT);
        end
`endif
        @(negedge CLK);
        RESET = 1'b0;
        READ = 1'b0;
        resync_ref();
        access(1, 0, 8'h05, 8'h00, b);
        checks++;
        if (b != 7) begin
            failures++;
            $display("FAIL rst_remiss got=%0d exp=7", b);
        end
`ifdef DCACHE_STATS_EN
        checks++;
        if (HIT_COUNT !== 16'd0 || MISS_COUNT !== 16'd1) begin
            failures++;
            $display("FAIL rst_restats got=%0d/%0d exp=0/1",
                     HIT_COUNT, MISS_COUNT);
        end
`endif
    endtask

    task automatic test_wrap_and_random();
        int b;
        logic [7:0] a, d;
        lat = 1;
        access(0, 1, 8'hFF, 8'h5C, b);
        access(1, 0, 8'h00, 8'h00, b);
        access(1, 0, 8'hFF, 8'h00, b);
        for (int i = 0; i < 80; i++) begin
            if (i == 40) begin
                idle();
                lat = 3;
            end
            a = 8'($urandom_range(0, 255));
            d = 8'($urandom);
            case ($urandom_range(0, 2))
                0: access(0, 1, a, d, b);
                1: access(1, 1, a, d, b);
                default: access(1, 0, a, d, b);
            endcase
        end
        idle();
        checks++;
        if (overlap != 0 || sb.size() != 0) begin
            failures++;
            $display("FAIL final got=ovl%0d/q%0d exp=0/0",
                     overlap, sb.size());
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            logic [31:0] w;
            w = init_word(i >> 2);
            ref_b[i] = w[(i % 4) * 8 +: 8];
        end
        test_reset();
        test_cold_miss();
        test_hits();
        test_dirty_evict();
        test_clean_evict();
        test_reset_mid_fetch();
        test_wrap_and_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
